// File: rtl/z_writeback_unit_pkg.sv
// Shared definitions for the Z writeback unit: ALUControl opcodes, writeback
// destination codes and the beat-sequencing FSM state type.
package z_writeback_unit_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_NEG  = 4'b0101;
    localparam logic [3:0] OP_SHL  = 4'b0110;
    localparam logic [3:0] OP_MUL  = 4'b0111;
    localparam logic [3:0] OP_SHR  = 4'b1000;
    localparam logic [3:0] OP_SHRA = 4'b1001;
    localparam logic [3:0] OP_DIV  = 4'b1010;
    localparam logic [3:0] OP_ROL  = 4'b1011;
    localparam logic [3:0] OP_ROR  = 4'b1100;

    localparam logic [1:0] DEST_GPR = 2'b00;
    localparam logic [1:0] DEST_LO  = 2'b01;
    localparam logic [1:0] DEST_HI  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_BEAT_GPR = 2'b01,
        S_BEAT_LO  = 2'b10,
        S_BEAT_HI  = 2'b11
    } wb_state_t;

    // MUL and DIV produce a full-width result that needs a LO and a HI beat;
    // everything else, undefined codes included, is a single GPR beat.
    function automatic logic is_two_beat(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/z_writeback_unit_if.sv
// ALU-result input and writeback output handshakes of the Z writeback unit.
// slave is the unit's view; master is the ALU/consumer side.
interface z_writeback_unit_if #(
    parameter int DATA_W = 32
);
    logic                  alu_valid;
    logic                  alu_ready;
    logic [3:0]            alu_op;
    logic [2*DATA_W-1:0]   alu_out;
    logic                  alu_zero;

    logic                  wb_valid;
    logic                  wb_ready;
    logic [DATA_W-1:0]     wb_data;
    logic [1:0]            wb_dest;

    modport master (
        output alu_valid, alu_op, alu_out, alu_zero, wb_ready,
        input  alu_ready, wb_valid, wb_data, wb_dest
    );

    modport slave (
        input  alu_valid, alu_op, alu_out, alu_zero, wb_ready,
        output alu_ready, wb_valid, wb_data, wb_dest
    );
endinterface

// File: rtl/z_writeback_unit_z_register.sv
// Z register pair plus captured Zero flag: a load-enabled 2*DATA_W register
// with asynchronous active-high clear.
module z_register #(
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                i_load,
    input  logic [2*DATA_W-1:0] i_d,
    input  logic                i_zero,
    output logic [2*DATA_W-1:0] o_q,
    output logic                o_zero
);

    logic [2*DATA_W-1:0] r_z;
    logic                r_zero;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_z    <= '0;
            r_zero <= 1'b0;
        end else if (i_load) begin
            r_z    <= i_d;
            r_zero <= i_zero;
        end
    end

    assign o_q    = r_z;
    assign o_zero = r_zero;

endmodule

// File: rtl/z_writeback_unit.sv
// Captures ALU results into Z and sequences them onto the 32-bit writeback
// path: one GPR beat, or LO then HI beats for MUL/DIV.
module z_writeback_unit
    import z_writeback_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clock,
    input  logic                clear,
    z_writeback_unit_if.slave   bus,
    output logic [DATA_W-1:0]   zhigh_q,
    output logic [DATA_W-1:0]   zlow_q,
    output logic                zero_q,
    output logic [CNT_W-1:0]    retired_cnt
);

    wb_state_t           r_state;
    logic                r_wb_valid;
    logic [DATA_W-1:0]   r_wb_data;
    logic [1:0]          r_wb_dest;
    logic [CNT_W-1:0]    r_retired_cnt;

    logic [2*DATA_W-1:0] w_z;
    logic                w_final_ack;
    logic                w_alu_ready;
    logic                w_accept;
    logic                w_two_beat;

    // Final beat completing frees the unit in the same edge, so a new result
    // can be accepted without a bubble.
    assign w_final_ack = bus.wb_ready && (r_state == S_BEAT_GPR || r_state == S_BEAT_HI);
    assign w_alu_ready = (r_state == S_IDLE) || w_final_ack;
    assign w_accept    = bus.alu_valid && w_alu_ready;
    assign w_two_beat  = is_two_beat(bus.alu_op);

    z_register #(.DATA_W(DATA_W)) u_z_register (
        .clock  (clock),
        .clear  (clear),
        .i_load (w_accept),
        .i_d    (bus.alu_out),
        .i_zero (bus.alu_zero),
        .o_q    (w_z),
        .o_zero (zero_q)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state       <= S_IDLE;
            r_wb_valid    <= 1'b0;
            r_wb_data     <= '0;
            r_wb_dest     <= DEST_GPR;
            r_retired_cnt <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state    <= w_two_beat ? S_BEAT_LO : S_BEAT_GPR;
                        r_wb_valid <= 1'b1;
                        r_wb_data  <= bus.alu_out[DATA_W-1:0];
                        r_wb_dest  <= w_two_beat ? DEST_LO : DEST_GPR;
                    end
                end
                S_BEAT_GPR, S_BEAT_HI: begin
                    if (bus.wb_ready) begin
                        r_retired_cnt <= r_retired_cnt + CNT_W'(1);
                        if (w_accept) begin
                            r_state    <= w_two_beat ? S_BEAT_LO : S_BEAT_GPR;
                            r_wb_data  <= bus.alu_out[DATA_W-1:0];
                            r_wb_dest  <= w_two_beat ? DEST_LO : DEST_GPR;
                        end else begin
                            r_state    <= S_IDLE;
                            r_wb_valid <= 1'b0;
                        end
                    end
                end
                S_BEAT_LO: begin
                    // Z was loaded on accept, so the high half is ready here.
                    if (bus.wb_ready) begin
                        r_state   <= S_BEAT_HI;
                        r_wb_data <= w_z[2*DATA_W-1:DATA_W];
                        r_wb_dest <= DEST_HI;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_wb_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.alu_ready = w_alu_ready;
    assign bus.wb_valid  = r_wb_valid;
    assign bus.wb_data   = r_wb_data;
    assign bus.wb_dest   = r_wb_dest;

    assign zhigh_q     = w_z[2*DATA_W-1:DATA_W];
    assign zlow_q      = w_z[DATA_W-1:0];
    assign retired_cnt = r_retired_cnt;

endmodule
